// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the sweep FSM states, the address-width helper and the "no zero register" marker.
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } rf_state_t;

  localparam int RF_NO_ZERO = -1;

  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: busy/zero/range masking, then optional write bypass.
// The storage array is passed in whole so each port is an independent mux.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int AW       = rf_clog2(DEPTH)
) (
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic             busy,
  input  logic             wr_accept,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic masked;
  logic hit;

  assign masked = busy || (int'(rdAddr) == ZERO_REG) || (int'(rdAddr) >= DEPTH);
  assign hit    = (BYPASS != 0) && wr_accept && (rdAddr == wrAddr);

  always_comb begin
    rdData = '0;
    if (masked) rdData = '0;
    else if (hit) rdData = wrData;
    else rdData = mem[rdAddr];
  end

endmodule

// File: rtl/regfile_param_bypass.sv
// Multi-read-port register file with hardwired zero register, write bypass and a
// sequential clear sweep that runs after reset and on request, gating writes and reads.
module regfile_param_bypass
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int AW       = rf_clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [AW-1:0]           wrAddr,
  input  logic [WIDTH-1:0]        wrData,
  input  logic [NUM_RD*AW-1:0]    rdAddr,
  output logic [NUM_RD*WIDTH-1:0] rdData,
  input  logic                    clear,
  output logic                    busy,
  output logic                    wr_err
);

  rf_state_t        state, state_nxt;
  logic [AW-1:0]    ptr, ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_accept;
  logic             sweeping;

  assign busy      = reset || (state == ST_CLEAR);
  assign sweeping  = !reset && (state == ST_CLEAR);
  assign wr_accept = write && !reset && (state == ST_IDLE) &&
                     (int'(wrAddr) != ZERO_REG) && (int'(wrAddr) < DEPTH);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (clear) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (ptr == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      wr_err <= write && (state == ST_CLEAR);
    end
  end

  // Storage has no reset; the sweep is the only thing that initialises it.
  always_ff @(posedge clk) begin
    if (sweeping) mem[ptr] <= '0;
    else if (wr_accept) mem[wrAddr] <= wrData;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .AW      (AW)
    ) u_rd (
      .mem      (mem),
      .busy     (busy),
      .wr_accept(wr_accept),
      .wrAddr   (wrAddr),
      .wrData   (wrData),
      .rdAddr   (rdAddr[i*AW +: AW]),
      .rdData   (rdData[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_param_bypass.sv
// Directed bench: default instance plus ZERO_REG=-1 and BYPASS=0 variants sharing the same stimulus.
module tb_regfile_param_bypass;

  localparam int W  = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [W-1:0]  wrData = '0;
  logic [2*AW-1:0] rdAddr = '0;
  logic          clear = 1'b0;

  logic [2*W-1:0] rd_m, rd_nz, rd_nb;
  logic busy_m, busy_nz, busy_nb;
  logic err_m, err_nz, err_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param_bypass dut (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr(rdAddr), .rdData(rd_m), .clear(clear), .busy(busy_m), .wr_err(err_m)
  );

  regfile_param_bypass #(.ZERO_REG(-1)) dut_nz (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr(rdAddr), .rdData(rd_nz), .clear(clear), .busy(busy_nz), .wr_err(err_nz)
  );

  regfile_param_bypass #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr(rdAddr), .rdData(rd_nb), .clear(clear), .busy(busy_nb), .wr_err(err_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, starting from the current cycle.
  task automatic count_busy(input string name, input int expected);
    int n;
    n = 0;
    while (busy_m && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== expected) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    rdAddr = {5'd5, 5'd3};
    #1;
    checks++;
    if (busy_m !== 1'b1 || err_m !== 1'b0 || rd_m !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b wr_err=%b rd=%h want busy=1 wr_err=0 rd=0", busy_m, err_m, rd_m);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rd_m !== '0 || rd_nz !== '0 || rd_nb !== '0) begin
      errors++;
      $display("FAIL sweep_rd_masked got %h want 0", rd_m);
    end
    count_busy("reset_sweep", 32);
    rdAddr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_m[W-1:0] !== 64'd0) begin
      errors++;
      $display("FAIL x5_after_sweep got %h want 0", rd_m[W-1:0]);
    end
  endtask

  task automatic test_write_bypass();
    write  = 1'b1;
    wrAddr = 5'd3;
    wrData = 64'hDEAD_BEEF_0000_0001;
    rdAddr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rd_m[W-1:0] !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want deadbeef00000001", rd_m[W-1:0]);
    end
    tick();
    write  = 1'b0;
    rdAddr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_m !== {2{64'hDEAD_BEEF_0000_0001}}) begin
      errors++;
      $display("FAIL x3_both_ports got %h want deadbeef00000001 x2", rd_m);
    end
  endtask

  task automatic test_zero_reg();
    write  = 1'b1;
    wrAddr = 5'd31;
    wrData = 64'h1234;
    tick();
    write  = 1'b0;
    rdAddr = {5'd31, 5'd31};
    #1;
    checks++;
    if (err_m !== 1'b0) begin
      errors++;
      $display("FAIL x31_no_wr_err got %b want 0", err_m);
    end
    checks++;
    if (rd_m !== '0) begin
      errors++;
      $display("FAIL x31_reads_zero got %h want 0", rd_m);
    end
    checks++;
    if (rd_nz !== {2{64'h1234}}) begin
      errors++;
      $display("FAIL x31_no_zero_reg got %h want 1234 x2", rd_nz);
    end
  endtask

  // Clear held for the first few sweep cycles must not extend it; write at cycle 10 is dropped.
  task automatic test_write_during_sweep();
    int n;
    clear = 1'b1;
    tick();
    n = 0;
    while (busy_m && n < 100) begin
      n++;
      clear  = (n < 5);
      write  = (n == 10);
      wrAddr = 5'd7;
      wrData = 64'hAA;
      tick();
      if (n == 10) begin
        checks++;
        if (err_m !== 1'b1) begin
          errors++;
          $display("FAIL wr_err_pulse got %b want 1", err_m);
        end
      end
      if (n == 11) begin
        checks++;
        if (err_m !== 1'b0) begin
          errors++;
          $display("FAIL wr_err_one_cycle got %b want 0", err_m);
        end
      end
    end
    clear = 1'b0;
    write = 1'b0;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL sweep_clear_ignored busy_cycles got %0d want 32", n);
    end
    rdAddr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_m !== '0) begin
      errors++;
      $display("FAIL x7_dropped got %h want 0", rd_m);
    end
  endtask

  task automatic test_clear_sweep();
    int bad;
    for (int i = 0; i <= 30; i++) begin
      write  = 1'b1;
      wrAddr = AW'(i);
      wrData = 64'(i);
      tick();
    end
    write  = 1'b0;
    rdAddr = {5'd17, 5'd30};
    #1;
    checks++;
    if (rd_m !== {64'd17, 64'd30}) begin
      errors++;
      $display("FAIL load_index got %h want 17/30", rd_m);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy("clear_sweep", 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rdAddr = {AW'(31 - i), AW'(i)};
      #1;
      if (rd_m !== '0 || rd_nz !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL all_cleared nonzero_reads got %0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid_sweep();
    write  = 1'b1;
    wrAddr = 5'd4;
    wrData = 64'h44;
    tick();
    write = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_m !== 1'b1 || err_m !== 1'b0 || rd_m !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs busy=%b wr_err=%b rd=%h want 1/0/0", busy_m, err_m, rd_m);
    end
    reset = 1'b0;
    count_busy("mid_reset_sweep", 32);
    write  = 1'b1;
    wrAddr = 5'd4;
    wrData = 64'h44;
    tick();
    wrData = 64'h55;
    rdAddr = {5'd0, 5'd4};
    #1;
    checks++;
    if (rd_nb[W-1:0] !== 64'h44) begin
      errors++;
      $display("FAIL no_bypass_old got %h want 44", rd_nb[W-1:0]);
    end
    checks++;
    if (rd_m[W-1:0] !== 64'h55) begin
      errors++;
      $display("FAIL bypass_new got %h want 55", rd_m[W-1:0]);
    end
    tick();
    write = 1'b0;
    #1;
    checks++;
    if (rd_nb[W-1:0] !== 64'h55) begin
      errors++;
      $display("FAIL no_bypass_next got %h want 55", rd_nb[W-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_write_during_sweep();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
